// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator decimal-entry block.
package calc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPEND,
    ST_DIVIDE,
    ST_DONE
  } state_e;

  localparam int DIGIT_MAX = 9;
  localparam int BCD_BASE  = 10;

  // Bit positions of the buttons in the debouncer instance array
  localparam int BTN_CLEAR  = 0;
  localparam int BTN_BACK   = 1;
  localparam int BTN_APPEND = 2;
  localparam int BTN_SIGN   = 3;

endpackage

// File: rtl/calc_button_debounce.sv
// Counter debouncer for one raw push button: 2-flop synchroniser, CYCLES-stable
// filter, then a one-cycle pulse on each debounced rising edge.
module calc_button_debounce #(
  parameter int CYCLES = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic event_o
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES + 1) : 1;

  logic [1:0]    sync_q;
  logic          stable_q;
  logic [CW-1:0] cnt_q;
  logic          event_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      event_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      event_q <= 1'b0;
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(CYCLES - 1)) begin
        // Input differed from the accepted level for CYCLES consecutive samples
        stable_q <= sync_q[1];
        cnt_q    <= '0;
        event_q  <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign event_o = event_q;

endmodule

// File: rtl/calc_decimal_entry.sv
// Decimal keystroke entry: debounced append/backspace/clear buttons build a binary operand.
// Optional signed entry is enabled by defining CALC_ENTRY_SIGN_EN.
module calc_decimal_entry
  import calc_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int MAX_DIGITS      = 5
) (
  input  logic             IN_clk,
  input  logic             IN_reset,
  input  logic             IN_enable,
  input  logic [3:0]       IN_digit,
  input  logic             IN_append_button,
  input  logic             IN_backspace_button,
  input  logic             IN_clear_button,
`ifdef CALC_ENTRY_SIGN_EN
  input  logic             IN_sign_button,
`endif
  output logic [WIDTH-1:0] OUT_value,
  output logic [2:0]       OUT_digit_count,
  output logic             OUT_busy,
  output logic             OUT_overflow,
  output logic             OUT_digit_error
);

`ifdef CALC_ENTRY_SIGN_EN
  localparam int NBTN = 4;
  localparam logic [WIDTH+3:0] LIMIT = {{4{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
`else
  localparam int NBTN = 3;
  localparam logic [WIDTH+3:0] LIMIT = {4'b0, {WIDTH{1'b1}}};
`endif
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] btn_ev;

  assign btn_raw[BTN_CLEAR]  = IN_clear_button;
  assign btn_raw[BTN_BACK]   = IN_backspace_button;
  assign btn_raw[BTN_APPEND] = IN_append_button;
`ifdef CALC_ENTRY_SIGN_EN
  assign btn_raw[BTN_SIGN]   = IN_sign_button;
`endif

  calc_button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_btn [NBTN-1:0] (
    .clk_i   (IN_clk),
    .rst_i   (IN_reset),
    .btn_i   (btn_raw),
    .event_o (btn_ev)
  );

  state_e           state_q;
  logic [WIDTH-1:0] mag_q;
  logic [2:0]       cnt_q;
  logic             ovf_q;
  logic             derr_q;
  logic             busy_q;
  logic [3:0]       digit_q;
  logic [WIDTH-1:0] div_q;
  logic [3:0]       rem_q;
  logic [BW-1:0]    bit_q;
`ifdef CALC_ENTRY_SIGN_EN
  logic             sign_q;
`endif

  // Events are honoured only from IDLE with the stage enabled; anything else is dropped
  logic go;
  assign go = IN_enable && (state_q == ST_IDLE);

  // value*10 + digit, wide enough that the range check cannot wrap
  logic [WIDTH+3:0] mag_x;
  logic [WIDTH+3:0] cand;
  assign mag_x = {4'b0, mag_q};
  assign cand  = (mag_x << 3) + (mag_x << 1) + {{WIDTH{1'b0}}, digit_q};

  // One restoring-division step by 10: dividend shifts out MSB-first, quotient shifts in
  logic [4:0]       rem_shift;
  logic             rem_ge;
  logic [3:0]       rem_d;
  logic [WIDTH-1:0] div_d;
  assign rem_shift = {rem_q, div_q[WIDTH-1]};
  assign rem_ge    = rem_shift >= 5'(BCD_BASE);
  assign rem_d     = 4'(rem_ge ? (rem_shift - 5'(BCD_BASE)) : rem_shift);
  assign div_d     = {div_q[WIDTH-2:0], rem_ge};

  always_ff @(posedge IN_clk) begin
    if (IN_reset) begin
      state_q <= ST_IDLE;
      mag_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      derr_q  <= 1'b0;
      busy_q  <= 1'b0;
      digit_q <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      bit_q   <= '0;
`ifdef CALC_ENTRY_SIGN_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      derr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            if (btn_ev[BTN_CLEAR]) begin
              mag_q <= '0;
              cnt_q <= '0;
              ovf_q <= 1'b0;
`ifdef CALC_ENTRY_SIGN_EN
              sign_q <= 1'b0;
`endif
            end else if (btn_ev[BTN_BACK]) begin
              div_q   <= mag_q;
              rem_q   <= '0;
              bit_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= ST_DIVIDE;
            end else if (btn_ev[BTN_APPEND]) begin
              digit_q <= IN_digit;
              state_q <= ST_APPEND;
            end
`ifdef CALC_ENTRY_SIGN_EN
            else if (btn_ev[BTN_SIGN]) begin
              // A zero magnitude never becomes negative
              if (!(mag_q == '0 && !sign_q)) sign_q <= ~sign_q;
            end
`endif
          end
        end
        ST_APPEND: begin
          state_q <= ST_IDLE;
          if (digit_q > 4'(DIGIT_MAX)) begin
            derr_q <= 1'b1;
          end else if (cand > LIMIT || cnt_q == 3'(MAX_DIGITS)) begin
            ovf_q <= 1'b1;
          end else begin
            mag_q <= cand[WIDTH-1:0];
            if (cand != '0) cnt_q <= cnt_q + 3'd1;
`ifdef CALC_ENTRY_SIGN_EN
            // Largest magnitude is only representable once the sign is negative
            ovf_q <= !sign_q && (cand == LIMIT);
`else
            ovf_q <= 1'b0;
`endif
          end
        end
        ST_DIVIDE: begin
          div_q <= div_d;
          rem_q <= rem_d;
          bit_q <= bit_q + BW'(1);
          if (bit_q == BW'(WIDTH - 1)) begin
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          mag_q   <= div_q;
          cnt_q   <= (cnt_q != 3'd0) ? cnt_q - 3'd1 : 3'd0;
          ovf_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef CALC_ENTRY_SIGN_EN
  assign OUT_value = sign_q ? (~mag_q + WIDTH'(1)) : mag_q;
`else
  assign OUT_value = mag_q;
`endif
  assign OUT_digit_count = cnt_q;
  assign OUT_busy        = busy_q;
  assign OUT_overflow    = ovf_q;
  assign OUT_digit_error = derr_q;

endmodule

// File: tb/tb_calc_decimal_entry.sv
// Directed bench for calc_decimal_entry (WIDTH=16, DEBOUNCE_CYCLES=4).
module tb_calc_decimal_entry;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, en, app, bsp, clr;
  logic [3:0]   digit;
  logic [W-1:0] value;
  logic [2:0]   count;
  logic         busy, ovf, derr;
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  calc_decimal_entry #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .MAX_DIGITS(5)) dut (
    .IN_clk              (clk),
    .IN_reset            (rst),
    .IN_enable           (en),
    .IN_digit            (digit),
    .IN_append_button    (app),
    .IN_backspace_button (bsp),
    .IN_clear_button     (clr),
`ifdef CALC_ENTRY_SIGN_EN
    .IN_sign_button      (1'b0),
`endif
    .OUT_value           (value),
    .OUT_digit_count     (count),
    .OUT_busy            (busy),
    .OUT_overflow        (ovf),
    .OUT_digit_error     (derr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit c, input bit b, input bit a);
    clr = c; bsp = b; app = a;
    tick(6);
    clr = 1'b0; bsp = 1'b0; app = 1'b0;
    tick(12);
  endtask

  task automatic key(input logic [3:0] d);
    digit = d;
    press(1'b0, 1'b0, 1'b1);
  endtask

  // Backspace with busy-cycle count; optionally pokes append while the divider runs
  task automatic backspace(input bit with_app, output int bc);
    bc = 0;
    for (int i = 0; i < 50; i++) begin
      bsp = (i < 6);
      app = with_app && (i >= 8) && (i < 14);
      @(negedge clk);
      if (busy) bc++;
    end
    bsp = 1'b0; app = 1'b0;
  endtask

  initial begin
    int  bc;
    bit  seen;
    rst = 1'b1; en = 1'b1; digit = 4'd0; app = 1'b0; bsp = 1'b0; clr = 1'b0;
    tick(3);
    chk("rst_value", value, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_derr", derr, 0);
    rst = 1'b0;
    tick(2);

    key(4'd1); key(4'd2); key(4'd3);
    chk("app123_value", value, 123);
    chk("app123_count", count, 3);
    chk("app123_ovf", ovf, 0);

    press(1'b1, 1'b0, 1'b0);
    chk("clear_value", value, 0);
    chk("clear_count", count, 0);

    key(4'd6); key(4'd5); key(4'd5); key(4'd3);
    chk("pre_max_value", value, 6553);
    key(4'd5);
    chk("max_value", value, 65535);
    chk("max_count", count, 5);
    chk("max_ovf", ovf, 0);
    key(4'd0);
    chk("count_ovf_flag", ovf, 1);
    chk("count_ovf_value", value, 65535);

    press(1'b1, 1'b0, 1'b0);
    chk("clear_ovf", ovf, 0);
    key(4'd6); key(4'd5); key(4'd5); key(4'd3); key(4'd6);
    chk("range_ovf_flag", ovf, 1);
    chk("range_ovf_value", value, 6553);
    chk("range_ovf_count", count, 4);

    press(1'b1, 1'b0, 1'b0);
    key(4'd4); key(4'd0); key(4'd9); key(4'd6);
    chk("pre_bs_value", value, 4096);
    backspace(1'b1, bc);
    chk("bs_busy_cycles", bc, 16);
    chk("bs_value", value, 409);
    chk("bs_count", count, 3);
    chk("bs_ovf", ovf, 0);

    digit = 4'hC; app = 1'b1;
    bc = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 6) app = 1'b0;
      @(negedge clk);
      if (derr) bc++;
    end
    chk("derr_pulses", bc, 1);
    chk("derr_value", value, 409);
    chk("derr_count", count, 3);

    digit = 4'd5;
    press(1'b1, 1'b0, 1'b1);
    chk("clr_app_value", value, 0);
    chk("clr_app_count", count, 0);

    digit = 4'd7;
    app = 1'b1; tick(1); app = 1'b0; tick(1); app = 1'b1; tick(1); app = 1'b0;
    tick(20);
    chk("bounce_value", value, 0);
    app = 1'b1; tick(4); app = 1'b0;
    tick(20);
    chk("held4_value", value, 7);
    chk("held4_count", count, 1);

    en = 1'b0;
    key(4'd2);
    chk("dis_app_value", value, 7);
    press(1'b1, 1'b0, 1'b0);
    chk("dis_clr_value", value, 7);
    en = 1'b1;
    tick(10);
    chk("reen_value", value, 7);

    bsp = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (i == 6) bsp = 1'b0;
      @(negedge clk);
      seen = busy;
    end
    bsp = 1'b0;
    chk("div_start", seen, 1);
    tick(6);
    chk("div_mid_busy", busy, 1);
    rst = 1'b1;
    tick(1);
    chk("abort_value", value, 0);
    chk("abort_busy", busy, 0);
    chk("abort_count", count, 0);
    rst = 1'b0;
    tick(2);
    key(4'd3);
    chk("post_abort_value", value, 3);
    chk("post_abort_count", count, 1);

    press(1'b1, 1'b0, 1'b0);
    backspace(1'b0, bc);
    chk("bs0_busy_cycles", bc, 16);
    chk("bs0_value", value, 0);
    chk("bs0_count", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
